// File: rtl/bp_block_decoder.sv
// Bit-serial decoder for ECG BP-mode blocks: a 4-bit bits-required header, then four
// sign-magnitude or two's-complement fields, each rebuilt as a signed J-bit sample.
module bp_block_decoder #(
    parameter int J = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   ecgidx,
    input  logic         bit_in,
    input  logic         bit_valid,
    output logic         bit_ready,
    output logic [J-1:0] sample_out,
    output logic         sample_valid,
    input  logic         sample_ready,
    output logic [1:0]   sample_idx,
    output logic         sample_last,
    output logic         err
);

    typedef enum logic [1:0] {S_HDR, S_SIGN, S_DATA, S_ZERO} state_t;

    localparam logic [3:0] J_HDR = 4'(J);
    localparam logic [J:0] ONE   = {{J{1'b0}}, 1'b1};

    state_t       state;
    logic [3:0]   hdr;
    logic [1:0]   hdr_cnt;
    logic         mode;
    logic         sgn;
    logic [J-1:0] acc;
    logic [3:0]   bit_cnt;
    logic [1:0]   smp_cnt;

    logic         out_free;
    logic         take;
    logic [3:0]   hdr_next;
    logic         hdr_tc;
    logic         hdr_zero;
    logic         hdr_legal;
    logic [J:0]   acc_next;
    logic         field_done;
    logic [J:0]   low_mask;
    logic [J:0]   top_mask;
    logic         field_sign;
    logic [J-1:0] sm_val;
    logic [J-1:0] tc_val;
    logic [J-1:0] field_val;

    // Both ports use valid/ready: a transfer happens on a rising edge where valid and
    // ready are both high; the output register may refill in the cycle it drains.
    always_comb begin
        out_free   = !sample_valid || sample_ready;
        bit_ready  = (state != S_ZERO) && out_free;
        take       = bit_valid && bit_ready;
        hdr_next   = {hdr[2:0], bit_in};
        hdr_tc     = (ecgidx == 2'd3);
        hdr_zero   = (hdr_next == 4'd0);
        hdr_legal  = !hdr_zero && (hdr_next <= J_HDR);
        acc_next   = {acc, bit_in};
        field_done = ((bit_cnt + 4'd1) == hdr);
        // top_mask marks bit hdr-1, the sign position of a TC field
        low_mask   = (ONE << hdr) - ONE;
        top_mask   = low_mask ^ (low_mask >> 1);
        field_sign = |(acc_next & top_mask);
        tc_val     = field_sign ? (acc_next[J-1:0] | ~low_mask[J-1:0]) : acc_next[J-1:0];
        sm_val     = sgn ? ({J{1'b0}} - acc_next[J-1:0]) : acc_next[J-1:0];
        field_val  = mode ? tc_val : sm_val;
    end

    assign sample_last = sample_valid && (sample_idx == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_HDR;
            hdr          <= 4'd0;
            hdr_cnt      <= 2'd0;
            mode         <= 1'b0;
            sgn          <= 1'b0;
            acc          <= '0;
            bit_cnt      <= 4'd0;
            smp_cnt      <= 2'd0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            sample_idx   <= 2'd0;
            err          <= 1'b0;
        end else begin
            err <= 1'b0;
            if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
            case (state)
                S_HDR: begin
                    if (take) begin
                        hdr     <= hdr_next;
                        hdr_cnt <= hdr_cnt + 2'd1;
                        if (hdr_cnt == 2'd3) begin
                            mode    <= hdr_tc;
                            smp_cnt <= 2'd0;
                            bit_cnt <= 4'd0;
                            acc     <= '0;
                            if (!hdr_tc && hdr_zero) begin
                                state <= S_ZERO;
                            end else if (hdr_legal) begin
                                state <= hdr_tc ? S_DATA : S_SIGN;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                end
                S_SIGN: begin
                    if (take) begin
                        sgn   <= bit_in;
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (take) begin
                        if (field_done) begin
                            sample_out   <= field_val;
                            sample_valid <= 1'b1;
                            sample_idx   <= smp_cnt;
                            smp_cnt      <= smp_cnt + 2'd1;
                            acc          <= '0;
                            bit_cnt      <= 4'd0;
                            if (smp_cnt == 2'd3) begin
                                state <= S_HDR;
                            end else begin
                                state <= mode ? S_DATA : S_SIGN;
                            end
                        end else begin
                            acc     <= acc_next[J-1:0];
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                S_ZERO: begin
                    // Zero block consumes no bits; one sample per free output slot
                    if (out_free) begin
                        sample_out   <= '0;
                        sample_valid <= 1'b1;
                        sample_idx   <= smp_cnt;
                        smp_cnt      <= smp_cnt + 2'd1;
                        if (smp_cnt == 2'd3) begin
                            state <= S_HDR;
                        end
                    end
                end
                default: state <= S_HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_block_decoder.sv
// Bench for bp_block_decoder: directed blocks from the test plan, then random blocks
// scored against an arithmetic reference model through an expected-sample queue.
module tb_bp_block_decoder;

    localparam int J = 10;
    localparam int W = J + 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   ecgidx;
    logic         bit_in;
    logic         bit_valid;
    logic         bit_ready;
    logic [J-1:0] sample_out;
    logic         sample_valid;
    logic         sample_ready = 1'b0;
    logic [1:0]   sample_idx;
    logic         sample_last;
    logic         err;

    int           n_checks = 0;
    int           n_fail = 0;
    logic [W-1:0] exp_q[$];
    int           rdy_mode = 0;
    int           err_seen = 0;
    int           err_exp = 0;
    bit           gap_en = 1'b0;
    bit           held_valid = 1'b0;
    logic [J-1:0] held_out;
    logic [1:0]   held_idx;
    logic [W-1:0] mon_e;

    bp_block_decoder #(.J(J)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ecgidx       (ecgidx),
        .bit_in       (bit_in),
        .bit_valid    (bit_valid),
        .bit_ready    (bit_ready),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_idx   (sample_idx),
        .sample_last  (sample_last),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic straight from the coding rules
    function automatic logic [J-1:0] sm_ref(input int s, input int m);
        int v;
        v = (s != 0) ? -m : m;
        return v[J-1:0];
    endfunction

    function automatic logic [J-1:0] tc_ref(input int w, input int f);
        int v;
        v = (f >= (1 << (w - 1))) ? f - (1 << w) : f;
        return v[J-1:0];
    endfunction

    // Consumer: picks sample_ready 3 time units after each edge and scores transfers
    always @(posedge clk) begin
        #3;
        case (rdy_mode)
            0:       sample_ready = 1'b1;
            1:       sample_ready = ($urandom_range(0, 2) != 0);
            default: sample_ready = 1'b0;
        endcase
        if (rst_n !== 1'b1) begin
            held_valid = 1'b0;
        end else begin
            if (err === 1'b1) err_seen++;
            if (sample_valid === 1'b1) begin
                if (held_valid) begin
                    chk("hold_out", sample_out, held_out);
                    chk("hold_idx", sample_idx, held_idx);
                end
                if (sample_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_sample", sample_valid, 0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("sample_out", sample_out, mon_e[J-1:0]);
                        chk("sample_idx", sample_idx, mon_e[J+1:J]);
                        chk("sample_last", sample_last, mon_e[J+1:J] == 2'd3);
                    end
                    held_valid = 1'b0;
                end else begin
                    held_valid = 1'b1;
                    held_out   = sample_out;
                    held_idx   = sample_idx;
                end
            end else begin
                held_valid = 1'b0;
            end
        end
    end

    task automatic send_bit(input logic b);
        int guard;
        if (gap_en && $urandom_range(0, 3) == 0) begin
            bit_valid = 1'b0;
            @(negedge clk);
        end
        bit_in    = b;
        bit_valid = 1'b1;
        guard     = 0;
        #1;
        while (bit_ready !== 1'b1 && guard < 500) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 500) chk("bit_accept", bit_ready, 1);
        @(negedge clk);
        bit_valid = 1'b0;
    endtask

    task automatic send_field(input int w, input int v, input bit lat);
        for (int i = w - 1; i >= 0; i--) begin
            if (lat && i == 0) chk("pre_valid", sample_valid, 0);
            send_bit(1'((v >> i) & 1));
        end
        if (lat) chk("latency_valid", sample_valid, 1);
    endtask

    task automatic sm_sample(input int w, input int s, input int m, input int idx, input bit lat);
        exp_q.push_back({2'(idx), sm_ref(s, m)});
        send_bit(1'(s));
        send_field(w, m, lat);
    endtask

    task automatic tc_sample(input int w, input int f, input int idx);
        exp_q.push_back({2'(idx), tc_ref(w, f)});
        send_field(w, f, 1'b0);
    endtask

    task automatic rand_block(input int tc, input int h);
        ecgidx = (tc != 0) ? 2'd3 : 2'($urandom_range(0, 2));
        send_field(4, h, 1'b0);
        ecgidx = 2'($urandom_range(0, 3));
        if (tc == 0 && h == 0) begin
            for (int i = 0; i < 4; i++) exp_q.push_back({2'(i), {J{1'b0}}});
        end else if (h > J || h == 0) begin
            err_exp++;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (tc != 0) tc_sample(h, $urandom_range(0, (1 << h) - 1), i);
                else sm_sample(h, $urandom_range(0, 1), $urandom_range(0, (1 << h) - 1), i, 1'b0);
            end
        end
    endtask

    initial begin
        logic [J-1:0] e1;
        int s1, m1, s2, guard;

        rst_n     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        ecgidx    = 2'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_sample_out", sample_out, 0);
        chk("rst_sample_valid", sample_valid, 0);
        chk("rst_sample_idx", sample_idx, 0);
        chk("rst_sample_last", sample_last, 0);
        chk("rst_err", err, 0);
        chk("rst_bit_ready", bit_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // SM block: 0101 | 0 00011 | 1 10001 | 0 00000 | 0 11111
        ecgidx = 2'd0;
        send_field(4, 5, 1'b0);
        sm_sample(5, 0, 3, 0, 1'b1);
        sm_sample(5, 1, 17, 1, 1'b1);
        sm_sample(5, 0, 0, 2, 1'b1);
        sm_sample(5, 0, 31, 3, 1'b1);

        // TC block with ecgidx changed after the header, then SM -512
        ecgidx = 2'd3;
        send_field(4, 3, 1'b0);
        ecgidx = 2'd0;
        tc_sample(3, 3, 0);
        tc_sample(3, 4, 1);
        tc_sample(3, 7, 2);
        tc_sample(3, 0, 3);
        send_field(4, 10, 1'b0);
        sm_sample(10, 1, 512, 0, 1'b0);
        for (int i = 1; i < 4; i++) sm_sample(10, $urandom_range(0, 1), $urandom_range(0, 1023), i, 1'b0);

        // Zero block: four zero samples on consecutive cycles, no bits consumed
        ecgidx = 2'd1;
        for (int i = 0; i < 4; i++) exp_q.push_back({2'(i), {J{1'b0}}});
        send_field(4, 0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("zero_bit_ready", bit_ready, 0);
            if (k > 0) chk("zero_valid", sample_valid, 1);
            @(negedge clk);
        end
        #1;
        chk("zero_end_bit_ready", bit_ready, 1);
        chk("zero_end_last", sample_last, 1);
        rand_block(1, 6);

        // Backpressure while sample 1 is valid
        ecgidx = 2'd0;
        send_field(4, 8, 1'b0);
        sm_sample(8, 1, 200, 0, 1'b0);
        rdy_mode = 2;
        s1 = $urandom_range(0, 1);
        m1 = $urandom_range(0, 255);
        e1 = sm_ref(s1, m1);
        sm_sample(8, s1, m1, 1, 1'b0);
        s2 = $urandom_range(0, 1);
        bit_in    = 1'(s2);
        bit_valid = 1'b1;
        repeat (5) begin
            #1;
            chk("bp_bit_ready", bit_ready, 0);
            chk("bp_valid", sample_valid, 1);
            chk("bp_out", sample_out, e1);
            @(negedge clk);
        end
        rdy_mode = 0;
        sm_sample(8, s2, $urandom_range(0, 255), 2, 1'b0);
        sm_sample(8, 0, 255, 3, 1'b0);

        // Illegal headers
        ecgidx = 2'd0;
        send_field(4, 11, 1'b0);
        err_exp++;
        chk("illegal_sm_err", err, 1);
        chk("illegal_sm_valid", sample_valid, 0);
        @(negedge clk);
        #1;
        chk("illegal_sm_err_clear", err, 0);
        ecgidx = 2'd3;
        send_field(4, 0, 1'b0);
        err_exp++;
        chk("illegal_tc_err", err, 1);
        chk("illegal_tc_valid", sample_valid, 0);
        @(negedge clk);
        #1;
        chk("illegal_tc_err_clear", err, 0);
        rand_block(0, 7);
        rand_block(1, J);

        // Reset after 7 accepted bits of a block
        ecgidx = 2'd0;
        send_field(4, 6, 1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_sample_out", sample_out, 0);
        chk("midrst_sample_valid", sample_valid, 0);
        chk("midrst_sample_idx", sample_idx, 0);
        chk("midrst_err", err, 0);
        chk("midrst_bit_ready", bit_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        rand_block(1, 5);
        rand_block(0, 10);

        // Random blocks with random backpressure and input gaps
        gap_en   = 1'b1;
        rdy_mode = 1;
        repeat (40) begin
            if ($urandom_range(0, 3) != 0) rand_block($urandom_range(0, 1), $urandom_range(1, J));
            else rand_block($urandom_range(0, 1), $urandom_range(0, 15));
        end

        gap_en   = 1'b0;
        rdy_mode = 0;
        guard    = 0;
        while (exp_q.size() != 0 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        chk("drain", exp_q.size(), 0);
        chk("err_count", err_seen, err_exp);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
